bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter and data/control mux for the shared system bus.
//  Up to 8 masters (CPU on port 7, test and DMA slaves on the others) raise req.
//  The block grants one master at a time with a one-hot ack and drives that

---
 rtl/bus_arbiter_rr_if.sv | 42 ++++
 rtl/bus_arbiter_rr.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_if
//   Bundle of the signals between the bus masters and the round-robin bus
//   arbiter.
//   Signals:
//     req      [7:0]            request per master, req[i] = master i
//     bus_in   [8*BUS_WIDTH]    packed master data, slice i = [i*BUS_WIDTH +: BUS_WIDTH]
//     ctrl_in  [8*CTRL_WIDTH]   packed master ctrl, same packing as bus_in
//     ack      [7:0]            registered one-hot grant
//     bus_out  [BUS_WIDTH]      data of the granted master, else 0
//     ctrl_out [CTRL_WIDTH]     ctrl of the granted master, else 0
//     busy                      high while a master owns the bus
//     owner    [2:0]            index of the current or last owner
//     timeout                   one-cycle pulse when a grant is force-released
//   Modports:
//     master - the requesting side (drives req/bus_in/ctrl_in)
//     slave  - the arbiter side
// ---------------------------------------------------------------------------
interface bus_arbiter_rr_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8
);
  logic [7:0]              req;
  logic [8*BUS_WIDTH-1:0]  bus_in;
  logic [8*CTRL_WIDTH-1:0] ctrl_in;
  logic [7:0]              ack;
  logic [BUS_WIDTH-1:0]    bus_out;
  logic [CTRL_WIDTH-1:0]   ctrl_out;
  logic                    busy;
  logic [2:0]              owner;
  logic                    timeout;

  modport master (
    output req, bus_in, ctrl_in,
    input  ack, bus_out, ctrl_out, busy, owner, timeout
  );

  modport slave (
    input  req, bus_in, ctrl_in,
    output ack, bus_out, ctrl_out, busy, owner, timeout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter and data/control mux for the shared system bus.
//   Eight masters raise req; one at a time is granted with a registered
//   one-hot ack and its data/ctrl slices are driven onto the bus. A tenure
//   limit force-releases an owner that has held the bus for MAX_HOLD cycles
//   while someone else is waiting. Every hand-over goes through a one-cycle
//   RELEASE gap with the bus idle.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-low
//     bus    - bus_arbiter_rr_if.slave (req, bus_in, ctrl_in in;
//              ack, bus_out, ctrl_out, busy, owner, timeout out)
//   Parameters:
//     BUS_WIDTH  - width of each master data slice and of bus_out
//     CTRL_WIDTH - width of each master ctrl slice and of ctrl_out
//     MAX_HOLD   - max grant cycles while another master requests (>= 2)
//     CNT_WIDTH  - tenure counter width, must hold MAX_HOLD
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int MAX_HOLD   = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_rr_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  logic [1:0]           state_q,   state_d;
  logic [7:0]           ack_q,     ack_d;
  logic [2:0]           owner_q,   owner_d;
  logic [2:0]           ptr_q,     ptr_d;
  logic [CNT_WIDTH-1:0] tenure_q,  tenure_d;
  logic                 timeout_q, timeout_d;

  logic [2:0] win;
  logic       others_req;
  logic       busy;

  // First requester found walking ascending from p with wrap-around.
  // The loop runs from the farthest position back to p so the last hit,
  // i.e. the nearest one to p, is the one returned.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + k[2:0];
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign win        = rr_pick(bus.req, ptr_q);
  assign others_req = |(bus.req & ~(8'h01 << owner_q));
  assign busy       = (state_q == S_GRANT);

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tenure_d  = tenure_q;
    timeout_d = 1'b0;
    case (state_q)
      // ptr_q already points past the last owner when coming from RELEASE
      S_IDLE, S_RELEASE: begin
        if (|bus.req) begin
          state_d  = S_GRANT;
          ack_d    = 8'h01 << win;
          owner_d  = win;
          tenure_d = '0;
        end else begin
          state_d = S_IDLE;
          ack_d   = '0;
        end
      end
      S_GRANT: begin
        if (!bus.req[owner_q]) begin
          // Voluntary drop wins over a simultaneous timeout.
          state_d = S_RELEASE;
          ack_d   = '0;
          ptr_d   = owner_q + 3'd1;
        end else if ((tenure_q == HOLD_LAST) && others_req) begin
          state_d   = S_RELEASE;
          ack_d     = '0;
          ptr_d     = owner_q + 3'd1;
          timeout_d = 1'b1;
        end else if (tenure_q != HOLD_LAST) begin
          tenure_d = tenure_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ack_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tenure_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tenure_q  <= tenure_d;
      timeout_q <= timeout_d;
    end
  end

  // Data mux follows the registered owner; the bus reads zero outside GRANT,
  // which also clears it asynchronously when reset forces state to IDLE.
  always_comb begin
    bus.bus_out  = '0;
    bus.ctrl_out = '0;
    if (busy) begin
      bus.bus_out  = bus.bus_in[owner_q*BUS_WIDTH +: BUS_WIDTH];
      bus.ctrl_out = bus.ctrl_in[owner_q*CTRL_WIDTH +: CTRL_WIDTH];
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy;
  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Directed scenarios followed by a randomized phase, all compared against a
//   behavioural model of the arbiter: who owns the bus, for how many cycles,
//   and where the round-robin search starts next.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;
  localparam int BW = 32;
  localparam int CW = 8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset;

  bus_arbiter_rr_if #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW)) bus ();

  bus_arbiter_rr #(
    .BUS_WIDTH (BW),
    .CTRL_WIDTH(CW),
    .MAX_HOLD  (MH),
    .CNT_WIDTH (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: m_own = granted master or -1, m_last = last owner,
  // m_ptr = search start, m_hold = cycles owned so far, m_to = timeout pulse.
  int         m_own, m_last, m_ptr, m_hold;
  bit         m_to;
  logic [7:0] prev_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_own    = -1;
    m_last   = 0;
    m_ptr    = 0;
    m_hold   = 0;
    m_to     = 1'b0;
    prev_ack = '0;
  endtask

  // Advance the model by one clock using the request vector seen at the edge.
  task automatic model_edge();
    logic [7:0] r;
    logic [7:0] mine;
    r    = bus.req;
    m_to = 1'b0;
    if (m_own >= 0) begin
      mine = 8'h01 << m_own;
      if (!r[m_own]) begin
        m_ptr = (m_own + 1) % 8;
        m_own = -1;
      end else if (m_hold >= MH && (r & ~mine) != 0) begin
        m_ptr = (m_own + 1) % 8;
        m_own = -1;
        m_to  = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (r != 0) begin
      m_own  = pick(r, m_ptr);
      m_last = m_own;
      m_hold = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0]    e_ack;
    logic [BW-1:0] e_bus;
    logic [CW-1:0] e_ctl;
    e_ack = '0;
    e_bus = '0;
    e_ctl = '0;
    if (m_own >= 0) begin
      e_ack = 8'h01 << m_own;
      e_bus = bus.bus_in[m_own*BW +: BW];
      e_ctl = bus.ctrl_in[m_own*CW +: CW];
    end
    check({tag, ".ack"},      64'(bus.ack),      64'(e_ack));
    check({tag, ".busy"},     64'(bus.busy),     64'(m_own >= 0));
    check({tag, ".owner"},    64'(bus.owner),    64'(m_last));
    check({tag, ".timeout"},  64'(bus.timeout),  64'(m_to));
    check({tag, ".bus_out"},  64'(bus.bus_out),  64'(e_bus));
    check({tag, ".ctrl_out"}, 64'(bus.ctrl_out), 64'(e_ctl));
    check({tag, ".onehot"},   64'($onehot0(bus.ack)), 64'(1));
    check({tag, ".gap"}, 64'(prev_ack != 0 && bus.ack != 0 && prev_ack != bus.ack), 64'(0));
    prev_ack = bus.ack;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) begin
      bus.bus_in[i*BW +: BW]  = $urandom;
      bus.ctrl_in[i*CW +: CW] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_all("rst");
    reset = 1'b1;
  endtask

  int order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    reset   = 1'b0;
    bus.req = '0;
    rand_data();
    do_reset();

    // 1: CPU alone
    bus.req = 8'h80;
    step("t1");
    check("t1.ack80",  64'(bus.ack),     64'(8'h80));
    check("t1.bus7",   64'(bus.bus_out), 64'(bus.bus_in[7*BW +: BW]));
    check("t1.owner7", 64'(bus.owner),   64'(7));

    // 2: ptr order then a one-cycle gap
    do_reset();
    bus.req = 8'h81;
    step("t2a");
    check("t2.ack01", 64'(bus.ack), 64'(8'h01));
    bus.req = 8'h80;
    step("t2b");
    check("t2.gap0", 64'(bus.ack), 64'(8'h00));
    step("t2c");
    check("t2.ack80", 64'(bus.ack), 64'(8'h80));

    // 3: tenure limit
    do_reset();
    bus.req = 8'h04;
    step("t3a");
    check("t3.ack04", 64'(bus.ack), 64'(8'h04));
    bus.req = 8'h24;
    for (int i = 0; i < 3; i++) begin
      step("t3h");
      check("t3.hold04", 64'(bus.ack), 64'(8'h04));
    end
    step("t3r");
    check("t3.rel_ack", 64'(bus.ack),     64'(8'h00));
    check("t3.to",      64'(bus.timeout), 64'(1));
    step("t3g");
    check("t3.ack20", 64'(bus.ack),     64'(8'h20));
    check("t3.to0",   64'(bus.timeout), 64'(0));

    // 4: sole requester is never forced off
    do_reset();
    bus.req = 8'h08;
    for (int i = 0; i < 200; i++) begin
      rand_data();
      step("t4");
      check("t4.ack08", 64'(bus.ack),     64'(8'h08));
      check("t4.noto",  64'(bus.timeout), 64'(0));
    end

    // 5: full rotation, each master drops one cycle after its grant
    do_reset();
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step("t5g");
      check("t5.order", 64'(bus.ack), 64'(8'h01 << order[g]));
      bus.req = bus.req & ~(8'h01 << order[g]);
      step("t5r");
      check("t5.gap", 64'(bus.ack), 64'(8'h00));
      bus.req = bus.req | (8'h01 << order[g]);
    end

    // 6: reset in the middle of a grant
    bus.req = 8'hFF;
    step("t6a");
    step("t6b");
    reset = 1'b0;
    #1;
    check("t6.ack_async", 64'(bus.ack),     64'(8'h00));
    check("t6.bus_async", 64'(bus.bus_out), 64'(0));
    model_reset();
    check_all("t6rst");
    reset = 1'b1;
    step("t6c");
    check("t6.ack01", 64'(bus.ack), 64'(8'h01));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_data();
      if ($urandom_range(3) == 0)
        bus.req = 8'($urandom) & 8'($urandom);
      else if ($urandom_range(1) == 0)
        bus.req = bus.req ^ (8'h01 << $urandom_range(7));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
